// File: rtl/plru_update_ctrl_pkg.sv
// Shared types and encodings for the PLRU-tree update controller.
// Tree-bit positions, FSM states, op and response-source codes.
package plru_update_ctrl_pkg;

  localparam int B_ROOT = 0;
  localparam int B_LO   = 1;
  localparam int B_HI   = 2;

  localparam logic RSP_SRC_CPU = 1'b0;
  localparam logic RSP_SRC_BUS = 1'b1;

  typedef enum logic {
    STATE_INIT = 1'b0,
    STATE_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    OP_TOUCH = 1'b0,
    OP_INVAL = 1'b1
  } op_t;

  function automatic logic [1:0] victim_of(
    input logic [2:0] b
  );
    if (b[B_ROOT])
      return b[B_HI] ? 2'd3 : 2'd2;
    else
      return b[B_LO] ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/plru_update_ctrl_if.sv
// Request/response bundle between cache and PLRU update controller.
// master = requester side, slave = controller side.
interface plru_update_ctrl_if #(
  parameter int AW = 4
) ();

  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic [AW-1:0] cpu_req_index;
  logic          cpu_req_hit;
  logic [1:0]    cpu_req_way;

  logic          bus_req_valid;
  logic          bus_req_ready;
  logic [AW-1:0] bus_req_index;
  logic [1:0]    bus_req_way;

  logic          rsp_valid;
  logic          rsp_src;
  logic [1:0]    rsp_way;
  logic [AW-1:0] rsp_index;

  modport master (
    output cpu_req_valid, cpu_req_index,
    output cpu_req_hit, cpu_req_way,
    output bus_req_valid, bus_req_index,
    output bus_req_way,
    input  cpu_req_ready, bus_req_ready,
    input  rsp_valid, rsp_src,
    input  rsp_way, rsp_index
  );

  modport slave (
    input  cpu_req_valid, cpu_req_index,
    input  cpu_req_hit, cpu_req_way,
    input  bus_req_valid, bus_req_index,
    input  bus_req_way,
    output cpu_req_ready, bus_req_ready,
    output rsp_valid, rsp_src,
    output rsp_way, rsp_index
  );

endinterface

// File: rtl/plru_next_calc.sv
// Combinational PLRU tree update: touch or invalidate one way.
// Also reports the victim way selected by the old tree bits.
module plru_next_calc
  import plru_update_ctrl_pkg::*;
(
  input  logic [2:0] old_bits,
  input  op_t        op,
  input  logic [1:0] way,
  output logic [2:0] new_bits,
  output logic [1:0] victim
);

  // Touch points away from way; invalidate points at it.
  always_comb begin
    new_bits = old_bits;
    victim   = victim_of(old_bits);
    if (op == OP_INVAL) begin
      new_bits[B_ROOT] = way[1];
      if (way[1]) new_bits[B_HI] = way[0];
      else        new_bits[B_LO] = way[0];
    end else begin
      new_bits[B_ROOT] = ~way[1];
      if (way[1]) new_bits[B_HI] = ~way[0];
      else        new_bits[B_LO] = ~way[0];
    end
  end

endmodule

// File: rtl/plru_update_ctrl.sv
// Read-modify-write controller for the 4-way PLRU tree RAM.
// Sweeps RAM to zero after reset, then serves bus and CPU requests.
module plru_update_ctrl
  import plru_update_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  plru_update_ctrl_if.slave     req,
  output logic [ADDR_WIDTH-1:0] plrut_r_addr,
  input  logic [DATA_WIDTH-1:0] plrut_r_data,
  output logic                  plrut_w_en,
  output logic [ADDR_WIDTH-1:0] plrut_w_addr,
  output logic [DATA_WIDTH-1:0] plrut_w_data,
  output logic                  init_done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  run;
  logic                  bus_acc;
  logic                  cpu_acc;

  logic                  s1_valid;
  logic                  s1_src;
  logic [ADDR_WIDTH-1:0] s1_idx;
  logic                  s1_hit;
  logic [1:0]            s1_way;

  logic                  fwd_en;
  logic [ADDR_WIDTH-1:0] fwd_addr;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  fwd_hit;

  logic [2:0]            old_bits;
  logic [2:0]            new_bits;
  logic [1:0]            victim;
  logic [1:0]            use_way;
  op_t                   op;

  assign run     = (state == STATE_RUN);
  assign bus_acc = run & req.bus_req_valid;
  assign cpu_acc = run & req.cpu_req_valid
                 & ~req.bus_req_valid;

  // Init sweep counter and INIT -> RUN transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STATE_INIT;
      cnt   <= '0;
    end else if (state == STATE_INIT) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= STATE_RUN;
    end
  end

  // Stage-1 capture of the accepted request (bus wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_src   <= RSP_SRC_CPU;
      s1_idx   <= '0;
      s1_hit   <= 1'b0;
      s1_way   <= '0;
    end else begin
      s1_valid <= bus_acc | cpu_acc;
      if (bus_acc) begin
        s1_src <= RSP_SRC_BUS;
        s1_idx <= req.bus_req_index;
        s1_hit <= 1'b0;
        s1_way <= req.bus_req_way;
      end else begin
        s1_src <= RSP_SRC_CPU;
        s1_idx <= req.cpu_req_index;
        s1_hit <= req.cpu_req_hit;
        s1_way <= req.cpu_req_way;
      end
    end
  end

  // Last write, replayed when RAM read would be stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_en   <= 1'b0;
      fwd_addr <= '0;
      fwd_data <= '0;
    end else begin
      fwd_en   <= plrut_w_en;
      fwd_addr <= plrut_w_addr;
      fwd_data <= plrut_w_data;
    end
  end

  assign fwd_hit  = fwd_en & (fwd_addr == s1_idx);
  assign old_bits = fwd_hit ? fwd_data : plrut_r_data;
  assign op       = (s1_src == RSP_SRC_BUS)
                  ? OP_INVAL : OP_TOUCH;
  assign use_way  = (s1_src == RSP_SRC_CPU && !s1_hit)
                  ? victim : s1_way;

  plru_next_calc u_calc (
    .old_bits (old_bits),
    .op       (op),
    .way      (use_way),
    .new_bits (new_bits),
    .victim   (victim)
  );

  // RAM ports, handshake readys and response fields.
  always_comb begin
    req.bus_req_ready = run;
    req.cpu_req_ready = run & ~req.bus_req_valid;
    init_done         = run;

    plrut_r_addr = '0;
    if (bus_acc)      plrut_r_addr = req.bus_req_index;
    else if (cpu_acc) plrut_r_addr = req.cpu_req_index;

    plrut_w_en   = ~run | s1_valid;
    plrut_w_addr = run ? s1_idx : cnt;
    plrut_w_data = run ? new_bits : '0;

    req.rsp_valid = s1_valid;
    req.rsp_src   = s1_valid & s1_src;
    req.rsp_way   = s1_valid ? use_way : 2'd0;
    req.rsp_index = s1_valid ? s1_idx : '0;
  end

endmodule
